// File: rtl/counter_bn.sv
// counter_bn: WIDTH-bit up/down/step/load counter, registered outputs.
// Ports: bn_clk, bn_reset (sync, high), bn_enable, bn_mode, bn_D ->
//   bn_Q value, bn_rco carry/borrow/clip pulse, bn_load load pulse.
// Macro COUNTER_BN_SAT_EN: saturate instead of wrapping.
module counter_bn #(
  parameter int unsigned     WIDTH     = 32,
  parameter longint unsigned DOWN_STEP = 3
) (
  input  logic             bn_clk,
  input  logic             bn_reset,
  input  logic             bn_enable,
  input  logic [1:0]       bn_mode,
  input  logic [WIDTH-1:0] bn_D,
  output logic             bn_load,
  output logic             bn_rco,
  output logic [WIDTH-1:0] bn_Q
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(DOWN_STEP);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic             load_q, load_d;

  logic [WIDTH-1:0] sub_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic             m_up, m_dn, m_st, m_ld;

  assign m_up = (bn_mode == 2'b00);
  assign m_dn = (bn_mode == 2'b01);
  assign m_st = (bn_mode == 2'b10);
  assign m_ld = (bn_mode == 2'b11);

  // One full-width chain each; MSB is carry-out / borrow-out.
  assign sub_b = m_st ? STEP : ONE;
  assign sum   = {1'b0, q_q} + {1'b0, ONE};
  assign dif   = {1'b0, q_q} - {1'b0, sub_b};

  always_comb begin
    q_d    = q_q;
    rco_d  = 1'b0;
    load_d = 1'b0;
    if (bn_enable) begin
      unique case (1'b1)
        m_up: begin
          rco_d = sum[WIDTH];
`ifdef COUNTER_BN_SAT_EN
          q_d = sum[WIDTH] ? q_q : sum[WIDTH-1:0];
`else
          q_d = sum[WIDTH-1:0];
`endif
        end
        m_dn, m_st: begin
          rco_d = dif[WIDTH];
`ifdef COUNTER_BN_SAT_EN
          q_d = dif[WIDTH] ? '0 : dif[WIDTH-1:0];
`else
          q_d = dif[WIDTH-1:0];
`endif
        end
        m_ld: begin
          q_d    = bn_D;
          load_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge bn_clk) begin
    if (bn_reset) begin
      q_q    <= '0;
      rco_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rco_q  <= rco_d;
      load_q <= load_d;
    end
  end

  assign bn_Q    = q_q;
  assign bn_rco  = rco_q;
  assign bn_load = load_q;

endmodule

// File: doc/counter_bn.md
COUNTER_BN -- requirements
Module: counter_bn

Interface
REQ-001 Parameter WIDTH, default 32, counter width in bits; legal range 2..64.
REQ-002 Parameter DOWN_STEP, default 3, decrement applied in mode 2'b10; legal range 1..2^WIDTH-1.
REQ-003 bn_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 bn_reset  input  1  synchronous, active-high reset, sampled on the bn_clk rising edge.
REQ-005 bn_enable  input  1  count/load qualifier; 0 = hold.
REQ-006 bn_mode  input  2  operation select: 00 up by 1, 01 down by 1, 10 down by DOWN_STEP, 11 parallel load.
REQ-007 bn_D  input  WIDTH  parallel load data.
REQ-008 bn_load  output  1  registered; one-cycle pulse confirming a parallel load.
REQ-009 bn_rco  output  1  registered; one-cycle ripple-carry/borrow-out pulse.
REQ-010 bn_Q  output  WIDTH  registered counter value.

Function
REQ-011 All outputs SHALL be registered; any operation sampled on edge N SHALL be visible on bn_Q/bn_rco/bn_load after edge N (latency 1 cycle).
REQ-012 bn_enable=0: bn_Q SHALL hold; bn_rco and bn_load SHALL be 0.
REQ-013 Mode 00: bn_Q <= (bn_Q+1) mod 2^WIDTH; bn_rco SHALL be 1 exactly when the old bn_Q was all-ones (wrap to 0).
REQ-014 Mode 01: bn_Q <= (bn_Q-1) mod 2^WIDTH; bn_rco SHALL be 1 exactly when the old bn_Q was 0 (wrap to all-ones).
REQ-015 Mode 10: bn_Q <= (bn_Q-DOWN_STEP) mod 2^WIDTH; bn_rco SHALL be 1 exactly when the old bn_Q < DOWN_STEP (borrow).
REQ-016 Mode 11: bn_Q <= bn_D; bn_load SHALL be 1 and bn_rco SHALL be 0 for that cycle.
REQ-017 bn_load SHALL be 0 in every cycle not following a mode-11 enabled edge.
REQ-018 bn_mode or bn_D changes SHALL take effect at the next sampling edge only; no state is held from a prior mode.
REQ-019 Arithmetic SHALL be a single WIDTH-bit carry/borrow chain across the whole word; no per-nibble segmentation and no per-slice carry outputs.
REQ-020 Consecutive enabled cycles SHALL update every cycle; continuous wrap SHALL pulse bn_rco once per wrap event.

Reset
REQ-021 bn_reset=1 at an edge SHALL force bn_Q=0, bn_rco=0, bn_load=0, overriding bn_enable and bn_mode.
REQ-022 Reset asserted mid-count SHALL discard the in-flight operation; the first enabled edge after deassertion SHALL operate on bn_Q=0.
REQ-023 No asynchronous behaviour; outputs are undefined only before the first reset edge.

Configuration
REQ-024 Macro COUNTER_BN_SAT_EN SHALL select saturating arithmetic when defined.
REQ-025 Defined: mode 00 at all-ones SHALL hold all-ones; modes 01/10 that would borrow SHALL load 0; bn_rco SHALL pulse in each cycle where saturation clipped the result.
REQ-026 Undefined: wrap-around behaviour of REQ-013..REQ-015 applies unchanged.
REQ-027 Load (mode 11), enable, and reset behaviour SHALL be identical in both builds.

Verification (WIDTH=8, DOWN_STEP=3 unless noted)
REQ-028 Reset, then mode 11, bn_D=8'hFE, 1 edge -> bn_Q=FE, bn_load=1, bn_rco=0; next edge with mode 00 -> bn_Q=FF, bn_load=0.
REQ-029 From bn_Q=FF, mode 00 -> bn_Q=00, bn_rco=1 (wrap build) / bn_Q=FF, bn_rco=1 (COUNTER_BN_SAT_EN build); following edge bn_rco=0 in wrap build.
REQ-030 From bn_Q=05, mode 10 for 3 edges -> bn_Q 02, FF (bn_rco=1 on this cycle only), FC; SAT build -> 02, 00 (bn_rco=1), 00 (bn_rco=1).
REQ-031 From bn_Q=00, mode 01 -> bn_Q=FF, bn_rco=1; then bn_enable=0 for 4 edges -> bn_Q=FF, bn_rco=0, bn_load=0 throughout.
REQ-032 Count up from 00 to 37, assert bn_reset with bn_enable=1 and mode 11, bn_D=AA -> bn_Q=00, bn_load=0; deassert, mode 00 -> bn_Q=01.
REQ-033 WIDTH=32, DOWN_STEP=7, bn_Q=32'h0000_0006, mode 10 -> bn_Q=32'hFFFF_FFFF, bn_rco=1; mode 00 next edge -> bn_Q=0, bn_rco=1.
